// File: rtl/tt_gpio_bank_ctrl_pkg.sv
// Shared definitions for the GPIO bank controller: config layout,
// direction-mode encodings and the pad drive decode.
package tt_gpio_bank_ctrl_pkg;

  localparam int unsigned CFG_W    = 4;
  localparam int unsigned SEL_W    = 5;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned CFG_FILT = 2;
  localparam int unsigned CFG_INV  = 3;

  typedef enum logic [1:0] {
    DIR_HIZ   = 2'b00,
    DIR_OUT   = 2'b01,
    DIR_BIDIR = 2'b10,
    DIR_OD    = 2'b11
  } dir_e;

  // Field order matches the cfg_data bit layout: [3] inv, [2] filt, [1:0] dir.
  typedef struct packed {
    logic inv;
    logic filt_en;
    dir_e dir;
  } pin_cfg_t;

  // Returns {pad_oe, pad_out} for a direction mode and the core request.
  function automatic logic [1:0] pad_drive(dir_e dir, logic core_out, logic core_oe);
    logic [1:0] drv;
    drv = 2'b00;
    case (dir)
      DIR_HIZ:   drv = 2'b00;
      DIR_OUT:   drv = {1'b1, core_out};
      DIR_BIDIR: drv = {core_oe, core_out};
      DIR_OD:    drv = {~core_out, 1'b0};
      default:   drv = 2'b00;
    endcase
    return drv;
  endfunction

endpackage

// File: rtl/tt_gpio_bank_ctrl_pin_ctrl.sv
// One pin of the GPIO bank: config register, registered pad drive,
// 2-flop input synchronizer, glitch filter, invert and edge detect.
module tt_gpio_pin_ctrl
  import tt_gpio_bank_ctrl_pkg::*;
#(
  parameter int unsigned FILT_CNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic [CFG_W-1:0] i_cfg,
  input  logic             i_core_out,
  input  logic             i_core_oe,
  input  logic             i_pad_in,
  output logic             o_core_in,
  output logic             o_rise,
  output logic             o_fall,
  output logic             o_pad_out,
  output logic             o_pad_oe
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CNT - 1);

  pin_cfg_t         r_cfg;
  logic             r_pad_out;
  logic             r_pad_oe;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_filt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_core_in;
  logic             r_rise;
  logic             r_fall;

  logic             w_filt_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_inv_nxt;
  logic             w_core_nxt;
  logic [1:0]       w_drive;

  // Filter next-state; a config write clears the counter and blocks acceptance that cycle.
  always_comb begin
    w_filt_nxt = r_filt;
    w_cnt_nxt  = '0;
    if (!r_cfg.filt_en) begin
      w_filt_nxt = r_sync2;
    end else if (!i_we && (r_sync2 != r_filt)) begin
      if (r_cnt == CNT_LAST) begin
        w_filt_nxt = r_sync2;
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end
  end

  // Conditioned level uses next-state filt/invert so core_in and its edge pulse register together.
  always_comb begin
    w_inv_nxt  = i_we ? i_cfg[CFG_INV] : r_cfg.inv;
    w_core_nxt = w_filt_nxt ^ w_inv_nxt;
    w_drive    = pad_drive(r_cfg.dir, i_core_out, i_core_oe);
  end

  // Config register and registered pad drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg     <= '0;
      r_pad_oe  <= 1'b0;
      r_pad_out <= 1'b0;
    end else begin
      if (i_we) begin
        r_cfg <= pin_cfg_t'(i_cfg);
      end
      r_pad_oe  <= w_drive[1];
      r_pad_out <= w_drive[0];
    end
  end

  // Input synchronizer, filter state, conditioned level and edge pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_filt    <= 1'b0;
      r_cnt     <= '0;
      r_core_in <= 1'b0;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
    end else begin
      r_sync1   <= i_pad_in;
      r_sync2   <= r_sync1;
      r_filt    <= w_filt_nxt;
      r_cnt     <= w_cnt_nxt;
      r_core_in <= w_core_nxt;
      r_rise    <= w_core_nxt & ~r_core_in;
      r_fall    <= ~w_core_nxt & r_core_in;
    end
  end

  assign o_core_in = r_core_in;
  assign o_rise    = r_rise;
  assign o_fall    = r_fall;
  assign o_pad_out = r_pad_out;
  assign o_pad_oe  = r_pad_oe;

endmodule

// File: rtl/tt_gpio_bank_ctrl.sv
// GPIO bank controller: decodes the indexed config write port and
// instantiates one pin controller per pad.
module tt_gpio_bank_ctrl
  import tt_gpio_bank_ctrl_pkg::*;
#(
  parameter int unsigned N_PINS   = 8,
  parameter int unsigned FILT_CNT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [SEL_W-1:0]  cfg_sel,
  input  logic [CFG_W-1:0]  cfg_data,
  input  logic [N_PINS-1:0] core_out,
  input  logic [N_PINS-1:0] core_oe,
  output logic [N_PINS-1:0] core_in,
  output logic [N_PINS-1:0] in_rise,
  output logic [N_PINS-1:0] in_fall,
  output logic [N_PINS-1:0] pad_out,
  output logic [N_PINS-1:0] pad_oe,
  input  logic [N_PINS-1:0] pad_in
);

  logic [N_PINS-1:0] w_we;

  // An out-of-range cfg_sel matches no pin, so the write is dropped.
  for (genvar gi = 0; gi < N_PINS; gi++) begin : g_pin
    assign w_we[gi] = cfg_we && (cfg_sel == SEL_W'(gi));

    tt_gpio_pin_ctrl #(
      .FILT_CNT(FILT_CNT)
    ) u_pin (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_we       (w_we[gi]),
      .i_cfg      (cfg_data),
      .i_core_out (core_out[gi]),
      .i_core_oe  (core_oe[gi]),
      .i_pad_in   (pad_in[gi]),
      .o_core_in  (core_in[gi]),
      .o_rise     (in_rise[gi]),
      .o_fall     (in_fall[gi]),
      .o_pad_out  (pad_out[gi]),
      .o_pad_oe   (pad_oe[gi])
    );
  end

endmodule

// File: tb/tb_tt_gpio_bank_ctrl.sv
// Scoreboard bench for tt_gpio_bank_ctrl: directed scenarios followed by
// random traffic, compared against a behavioural per-pin model.
module tb_tt_gpio_bank_ctrl;

  localparam int unsigned NP = 8;
  localparam int unsigned FC = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [4:0]    cfg_sel = '0;
  logic [3:0]    cfg_data = '0;
  logic [NP-1:0] core_out = '0;
  logic [NP-1:0] core_oe = '0;
  logic [NP-1:0] pad_in = '0;
  logic [NP-1:0] core_in, in_rise, in_fall, pad_out, pad_oe;

  always #5 clk = ~clk;

  tt_gpio_bank_ctrl #(
    .N_PINS  (NP),
    .FILT_CNT(FC)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cfg_we  (cfg_we),
    .cfg_sel (cfg_sel),
    .cfg_data(cfg_data),
    .core_out(core_out),
    .core_oe (core_oe),
    .core_in (core_in),
    .in_rise (in_rise),
    .in_fall (in_fall),
    .pad_out (pad_out),
    .pad_oe  (pad_oe),
    .pad_in  (pad_in)
  );

  typedef struct {
    logic [NP-1:0] pout;
    logic [NP-1:0] poe;
    logic [NP-1:0] cin;
    logic [NP-1:0] rise;
    logic [NP-1:0] fall;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: pad drive from the mode table, the input seen through
  // a two-stage delay line, and a filter accepting a new level only after
  // it has disagreed with the held level for FC uninterrupted cycles.
  bit [3:0]    m_cfg[NP];
  bit          m_dly[NP][2];
  bit          m_held[NP];
  int          m_run[NP];
  bit          m_level[NP];

  function automatic void model_reset();
    for (int p = 0; p < NP; p++) begin
      m_cfg[p]    = '0;
      m_dly[p][0] = 1'b0;
      m_dly[p][1] = 1'b0;
      m_held[p]   = 1'b0;
      m_run[p]    = 0;
      m_level[p]  = 1'b0;
    end
  endfunction

  function automatic exp_t model_step(bit we, int sel, bit [3:0] data,
                                      logic [NP-1:0] co, logic [NP-1:0] coe,
                                      logic [NP-1:0] pin);
    exp_t e;
    for (int p = 0; p < NP; p++) begin
      bit hit;
      bit seen;
      bit lvl;
      hit  = we && (sel == p);
      case (m_cfg[p][1:0])
        2'd0: begin e.poe[p] = 1'b0;    e.pout[p] = 1'b0;  end
        2'd1: begin e.poe[p] = 1'b1;    e.pout[p] = co[p]; end
        2'd2: begin e.poe[p] = coe[p];  e.pout[p] = co[p]; end
        default: begin e.poe[p] = !co[p]; e.pout[p] = 1'b0; end
      endcase
      seen = m_dly[p][1];
      if (!m_cfg[p][2]) begin
        m_held[p] = seen;
        m_run[p]  = 0;
      end else if (hit || seen == m_held[p]) begin
        m_run[p] = 0;
      end else begin
        m_run[p] = m_run[p] + 1;
        if (m_run[p] >= FC) begin
          m_held[p] = seen;
          m_run[p]  = 0;
        end
      end
      m_dly[p][1] = m_dly[p][0];
      m_dly[p][0] = pin[p];
      if (hit) m_cfg[p] = data;
      lvl        = m_held[p] ^ m_cfg[p][3];
      e.cin[p]   = lvl;
      e.rise[p]  = lvl && !m_level[p];
      e.fall[p]  = !lvl && m_level[p];
      m_level[p] = lvl;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [NP-1:0] act, input logic [NP-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge: drive one cycle of inputs, predict, advance to next negedge.
  task automatic step(input bit we, input int sel, input bit [3:0] data,
                      input logic [NP-1:0] co, input logic [NP-1:0] coe,
                      input logic [NP-1:0] pin);
    cfg_we   = we;
    cfg_sel  = 5'(sel);
    cfg_data = data;
    core_out = co;
    core_oe  = coe;
    pad_in   = pin;
    sb.push_back(model_step(we, sel, data, co, coe, pin));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 4'h0, core_out, core_oe, pad_in);
  endtask

  task automatic wr(input int sel, input bit [3:0] data);
    step(1'b1, sel, data, core_out, core_oe, pad_in);
  endtask

  task automatic set_pad(input int bitn, input bit v, input int n);
    logic [NP-1:0] p;
    p = pad_in;
    p[bitn] = v;
    step(1'b0, 0, 4'h0, core_out, core_oe, p);
    idle(n - 1);
  endtask

  // Monitor: every cycle the DUT presents a full output vector.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pad_out", pad_out, e.pout);
        chk("pad_oe",  pad_oe,  e.poe);
        chk("core_in", core_in, e.cin);
        chk("in_rise", in_rise, e.rise);
        chk("in_fall", in_fall, e.fall);
      end
    end
  end

  initial begin
    logic [NP-1:0] p;
    logic [NP-1:0] co;
    model_reset();
    pad_in = '1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pad_oe",  pad_oe,  '0);
    chk("rst_pad_out", pad_out, '0);
    chk("rst_core_in", core_in, '0);
    chk("rst_in_rise", in_rise, '0);
    chk("rst_in_fall", in_fall, '0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(20);

    // Pin 3 push-pull then open-drain.
    co = core_out; co[3] = 1'b1;
    step(1'b1, 3, 4'b0001, co, core_oe, pad_in);
    idle(3);
    wr(3, 4'b0011);
    idle(3);
    co[3] = 1'b0;
    step(1'b0, 0, 4'h0, co, core_oe, pad_in);
    idle(3);

    // Pin 0 with filter: 3-cycle glitch, then a step.
    wr(0, 4'b0100);
    set_pad(0, 1'b0, 10);
    set_pad(0, 1'b1, 3);
    set_pad(0, 1'b0, 10);
    set_pad(0, 1'b1, 10);

    // Pin 1 unfiltered fall, then invert.
    set_pad(1, 1'b0, 6);
    wr(1, 4'b1000);
    idle(5);

    // Out-of-range write.
    wr(NP, 4'hF);
    wr(31, 4'hD);
    idle(5);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      p = pad_in;
      for (int b = 0; b < NP; b++)
        if ($urandom_range(0, 5) == 0) p[b] = ~p[b];
      step($urandom_range(0, 3) == 0, int'($urandom_range(0, 9)), 4'($urandom),
           NP'($urandom), NP'($urandom), p);
    end

    // All pins push-pull, then reset mid-cycle.
    for (int q = 0; q < NP; q++) wr(q, 4'b0001);
    idle(3);
    @(posedge clk);
    #3;
    chk("pre_rst_pad_oe", pad_oe, '1);
    rst_n = 1'b0;
    #1;
    chk("async_pad_oe",  pad_oe,  '0);
    chk("async_pad_out", pad_out, '0);
    chk("async_core_in", core_in, '0);
    chk("async_in_rise", in_rise, '0);
    chk("async_in_fall", in_fall, '0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pad_in = '1;
    idle(12);

    repeat (3) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d expected=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
